kim_tty_bridge: RTL and testbench

Byte-oriented serial bridge for the KIM-1 teletype port. Deserialises the bit-banged `TTYO` line driven by the KIM-1 monitor into bytes on a valid/ready stream. Serialises bytes from a host stream onto the `TTYI` line read by the KIM-1 through RIOT-002 PA7. Sits directly beside the KIM-1 core: it consumes its `TTYO` output and produces its `TTYI` input.

---
 rtl/kim_tty_pkg.sv | 22 ++
 rtl/kim_tty_rx_fifo.sv | 63 ++++++
 rtl/kim_tty_bridge.sv | 269 ++++++++++++++++++++++++++
 tb/tb_kim_tty_bridge.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kim_tty_pkg.sv
// kim_tty_pkg: shared FSM state types and sizing constants for the KIM-1 teletype bridge.
package kim_tty_pkg;

    localparam int RX_FIFO_DEPTH = 4;
    localparam int BIT_CNT_W     = 16;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_MARK
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/kim_tty_rx_fifo.sv
// kim_tty_rx_fifo: small synchronous FIFO holding received bytes; DEPTH must be at least 2.
module kim_tty_rx_fifo
    import kim_tty_pkg::*;
#(
    parameter int DEPTH  = RX_FIFO_DEPTH,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/kim_tty_bridge.sv
// kim_tty_bridge: deserialises KIM-1 TTYO into a byte stream and serialises host bytes onto TTYI.
// Build option KIM_TTY_RX_FIFO_EN selects a RX_FIFO_DEPTH-entry receive FIFO instead of one holding register.
module kim_tty_bridge
    import kim_tty_pkg::*;
#(
    parameter int BIT_DIV   = 5208,
    parameter int STOP_BITS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ttyo,
    output logic       ttyi,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       rx_framing_err,
    output logic       rx_overrun
);

    localparam logic [BIT_CNT_W-1:0] HALF_RELOAD = BIT_CNT_W'(BIT_DIV / 2 - 1);
    localparam logic [BIT_CNT_W-1:0] FULL_RELOAD = BIT_CNT_W'(BIT_DIV - 1);
    localparam logic                 STOP_LAST   = 1'(STOP_BITS - 1);

    logic                 ttyo_p0;
    logic                 ttyo_s;

    rx_state_t            rx_state, rx_state_nxt;
    logic [BIT_CNT_W-1:0] rx_cnt, rx_cnt_nxt;
    logic [7:0]           rx_sh, rx_sh_nxt;
    logic [2:0]           rx_bit, rx_bit_nxt;
    logic                 rx_push;
    logic                 rx_ferr;
    logic                 rx_pop;
    logic                 rx_drop;

    tx_state_t            tx_state, tx_state_nxt;
    logic [BIT_CNT_W-1:0] tx_cnt, tx_cnt_nxt;
    logic [7:0]           tx_sh, tx_sh_nxt;
    logic [2:0]           tx_bit, tx_bit_nxt;
    logic                 tx_stop, tx_stop_nxt;
    logic                 ttyi_nxt;
    logic                 tx_last;
    logic                 tx_take;

    // ---- stage p0/p1: two-flop synchroniser, idles at mark
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ttyo_p0 <= 1'b1;
            ttyo_s  <= 1'b1;
        end else begin
            ttyo_p0 <= ttyo;
            ttyo_s  <= ttyo_p0;
        end
    end

    // ---- receiver FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_sh    <= '0;
            rx_bit   <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_sh    <= rx_sh_nxt;
            rx_bit   <= rx_bit_nxt;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_sh_nxt    = rx_sh;
        rx_bit_nxt   = rx_bit;
        rx_push      = 1'b0;
        rx_ferr      = 1'b0;
        if (rx_state != RX_IDLE && rx_state != RX_WAIT_MARK && rx_cnt != '0) begin
            rx_cnt_nxt = rx_cnt - 1'b1;
        end
        case (rx_state)
            RX_IDLE: begin
                if (!ttyo_s) begin
                    rx_state_nxt = RX_START;
                    rx_cnt_nxt   = HALF_RELOAD;
                end
            end
            RX_START: begin
                if (rx_cnt == '0) begin
                    if (ttyo_s) begin
                        rx_state_nxt = RX_IDLE;
                    end else begin
                        rx_state_nxt = RX_DATA;
                        rx_cnt_nxt   = FULL_RELOAD;
                        rx_bit_nxt   = '0;
                    end
                end
            end
            RX_DATA: begin
                if (rx_cnt == '0) begin
                    rx_sh_nxt  = {ttyo_s, rx_sh[7:1]};
                    rx_cnt_nxt = FULL_RELOAD;
                    rx_bit_nxt = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) begin
                        rx_state_nxt = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (rx_cnt == '0) begin
                    if (ttyo_s) begin
                        rx_push      = 1'b1;
                        rx_state_nxt = RX_IDLE;
                    end else begin
                        rx_ferr      = 1'b1;
                        rx_state_nxt = RX_WAIT_MARK;
                    end
                end
            end
            RX_WAIT_MARK: begin
                // Stay here through a break so it reports a single framing error.
                if (ttyo_s) begin
                    rx_state_nxt = RX_IDLE;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    // ---- receive byte store
`ifdef KIM_TTY_RX_FIFO_EN
    logic fifo_full;
    logic fifo_empty;

    kim_tty_rx_fifo #(
        .DEPTH  (RX_FIFO_DEPTH),
        .DATA_W (8)
    ) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push),
        .push_data (rx_sh),
        .pop       (rx_pop),
        .pop_data  (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rx_valid = !fifo_empty;
    assign rx_pop   = rx_valid && rx_ready;
    assign rx_drop  = rx_push && fifo_full && !rx_pop;
`else
    logic [7:0] hold_data;
    logic       hold_valid;

    assign rx_valid = hold_valid;
    assign rx_data  = hold_data;
    assign rx_pop   = hold_valid && rx_ready;
    assign rx_drop  = rx_push && hold_valid && !rx_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
        end else if (rx_push && !rx_drop) begin
            hold_data  <= rx_sh;
            hold_valid <= 1'b1;
        end else if (rx_pop) begin
            hold_valid <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_framing_err <= 1'b0;
            rx_overrun     <= 1'b0;
        end else begin
            rx_framing_err <= rx_ferr;
            rx_overrun     <= rx_drop;
        end
    end

    // ---- transmitter FSM
    // Ready is raised in the final cycle of the last stop bit so a queued byte starts with no idle gap.
    assign tx_last  = (tx_state == TX_STOP) && (tx_cnt == '0) && (tx_stop == STOP_LAST);
    assign tx_ready = (tx_state == TX_IDLE) || tx_last;
    assign tx_take  = tx_valid && tx_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_sh    <= '0;
            tx_bit   <= '0;
            tx_stop  <= 1'b0;
            ttyi     <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_sh    <= tx_sh_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_stop  <= tx_stop_nxt;
            ttyi     <= ttyi_nxt;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_sh_nxt    = tx_sh;
        tx_bit_nxt   = tx_bit;
        tx_stop_nxt  = tx_stop;
        ttyi_nxt     = ttyi;
        if (tx_state != TX_IDLE && tx_cnt != '0) begin
            tx_cnt_nxt = tx_cnt - 1'b1;
        end
        if (tx_take) begin
            tx_state_nxt = TX_START;
            tx_cnt_nxt   = FULL_RELOAD;
            tx_sh_nxt    = tx_data;
            ttyi_nxt     = 1'b0;
        end else begin
            case (tx_state)
                TX_START: begin
                    if (tx_cnt == '0) begin
                        tx_state_nxt = TX_DATA;
                        tx_cnt_nxt   = FULL_RELOAD;
                        tx_bit_nxt   = '0;
                        ttyi_nxt     = tx_sh[0];
                        tx_sh_nxt    = {1'b0, tx_sh[7:1]};
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == '0) begin
                        tx_cnt_nxt = FULL_RELOAD;
                        if (tx_bit == 3'd7) begin
                            tx_state_nxt = TX_STOP;
                            tx_stop_nxt  = 1'b0;
                            ttyi_nxt     = 1'b1;
                        end else begin
                            tx_bit_nxt = tx_bit + 3'd1;
                            ttyi_nxt   = tx_sh[0];
                            tx_sh_nxt  = {1'b0, tx_sh[7:1]};
                        end
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == '0) begin
                        if (tx_stop == STOP_LAST) begin
                            tx_state_nxt = TX_IDLE;
                        end else begin
                            tx_stop_nxt = tx_stop + 1'b1;
                            tx_cnt_nxt  = FULL_RELOAD;
                        end
                    end
                end
                default: begin
                    tx_state_nxt = TX_IDLE;
                    ttyi_nxt     = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kim_tty_bridge.sv
// tb_kim_tty_bridge: randomized self-checking bench for kim_tty_bridge with BIT_DIV=16, STOP_BITS=2.
module tb_kim_tty_bridge;

    localparam int BD    = 16;
    localparam int SB    = 2;
    localparam int FRAME = (1 + 8 + SB) * BD;
`ifdef KIM_TTY_RX_FIFO_EN
    localparam int STORE_CAP = 4;
`else
    localparam int STORE_CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       ttyo;
    logic       ttyi;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       rx_framing_err;
    logic       rx_overrun;

    int errors   = 0;
    int checks   = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    kim_tty_bridge #(
        .BIT_DIV   (BD),
        .STOP_BITS (SB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ttyo           (ttyo),
        .ttyi           (ttyi),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_framing_err (rx_framing_err),
        .rx_overrun     (rx_overrun)
    );

    always @(posedge clk) begin
        if (rx_framing_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
        if (rx_overrun === 1'b1)     ovr_cnt  <= ovr_cnt + 1;
    end

    // Every byte the consumer accepts, in order.
    always @(negedge clk) begin
        if (reset === 1'b1 && rx_valid === 1'b1 && rx_ready === 1'b1) got_q.push_back(rx_data);
    end

    // Serial line level of bit j of an 8N1-style frame: start 0, data LSB first, then mark.
    function automatic logic frame_bit(input logic [7:0] d, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return d[j-1];
        return 1'b1;
    endfunction

    task automatic drive_rx(input logic [7:0] d, input logic stop_val);
        @(posedge clk); #1;
        for (int j = 0; j < 10; j++) begin
            ttyo = (j == 9) ? stop_val : frame_bit(d, j);
            repeat (BD) @(posedge clk);
            #1;
        end
        ttyo = 1'b1;
    endtask

    task automatic check_rx_stream(input string name);
        for (int t = 0; t < 400 && got_q.size() < exp_q.size(); t++) @(negedge clk);
        repeat (4) @(negedge clk);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d bytes, expected %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_byte%0d: got %02h expected %02h", name, i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic tx_frames(input logic [7:0] d0, input logic [7:0] d1, input int n);
        logic exp_bits[$];
        logic exp_rdy;
        for (int j = 0; j < 11; j++) exp_bits.push_back(frame_bit(d0, j));
        if (n > 1) for (int j = 0; j < 11; j++) exp_bits.push_back(frame_bit(d1, j));
        @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL tx_ready_idle: got %b expected 1", tx_ready);
        end
        tx_data  = d0;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        if (n > 1) tx_data = d1;
        else       tx_valid = 1'b0;
        // Sample k lies in the (k+1)-th cycle after the handshake; ready shows in cycle FRAME.
        for (int k = 0; k < n * FRAME; k++) begin
            @(negedge clk);
            exp_rdy = ((k % FRAME) == FRAME - 1);
            checks++;
            if (ttyi !== exp_bits[k / BD]) begin
                errors++;
                $display("FAIL tx_bit k=%0d: got ttyi=%b expected %b", k, ttyi, exp_bits[k / BD]);
            end
            checks++;
            if (tx_ready !== exp_rdy) begin
                errors++;
                $display("FAIL tx_ready k=%0d: got %b expected %b", k, tx_ready, exp_rdy);
            end
            if (k == FRAME - 1 && n > 1) begin
                @(posedge clk); #1;
                tx_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (ttyi !== 1'b1) begin
            errors++;
            $display("FAIL tx_after_idle: got ttyi=%b expected 1", ttyi);
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL tx_after_ready: got %b expected 1", tx_ready);
        end
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ttyi !== 1'b1) begin errors++; $display("FAIL reset_ttyi: got %b expected 1", ttyi); end
        checks++;
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); end
        checks++;
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        checks++;
        if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %02h expected 00", rx_data); end
        checks++;
        if ({rx_framing_err, rx_overrun} !== 2'b00) begin
            errors++;
            $display("FAIL reset_pulses: got %b%b expected 00", rx_framing_err, rx_overrun);
        end
        reset = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (ttyi !== 1'b1 || tx_ready !== 1'b1 || rx_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL idle_hold: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_rx_basic();
        int f0;
        int o0;
        logic [7:0] d;
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        rx_ready = 1'b1;
        exp_q.push_back(8'h5A);
        fork
            drive_rx(8'h5A, 1'b1);
            begin
                @(posedge clk); #1;
                repeat (154) @(posedge clk);
                #1;
                checks++;
                if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_early: got rx_valid=%b expected 0", rx_valid); end
                @(posedge clk); #1;
                checks++;
                if (rx_valid !== 1'b1) begin errors++; $display("FAIL rx_latency: got rx_valid=%b expected 1", rx_valid); end
                checks++;
                if (rx_data !== 8'h5A) begin errors++; $display("FAIL rx_5a_data: got %02h expected 5a", rx_data); end
            end
        join
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom_range(0, 255));
            exp_q.push_back(d);
            drive_rx(d, 1'b1);
        end
        check_rx_stream("rx_basic");
        checks++;
        if (ferr_cnt - f0 != 0) begin errors++; $display("FAIL rx_basic_ferr: got %0d pulses expected 0", ferr_cnt - f0); end
        checks++;
        if (ovr_cnt - o0 != 0) begin errors++; $display("FAIL rx_basic_ovr: got %0d pulses expected 0", ovr_cnt - o0); end
    endtask

    task automatic test_tx();
        tx_frames(8'hA5, 8'h00, 1);
        tx_frames(8'($urandom_range(0, 255)), 8'h00, 1);
    endtask

    task automatic test_back_to_back();
        tx_frames(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 2);
    endtask

    task automatic test_break();
        int f0;
        f0 = ferr_cnt;
        rx_ready = 1'b1;
        @(posedge clk); #1;
        ttyo = 1'b0;
        repeat (300) @(posedge clk);
        #1 ttyo = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL break_ferr: got %0d pulses expected 1", ferr_cnt - f0); end
        checks++;
        if (got_q.size() != 0 || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL break_stored: got %0d bytes rx_valid=%b expected 0 bytes", got_q.size(), rx_valid);
        end
        exp_q.push_back(8'h31);
        drive_rx(8'h31, 1'b1);
        check_rx_stream("after_break");
        checks++;
        if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL after_break_ferr: got %0d pulses expected 1", ferr_cnt - f0); end
    endtask

    task automatic test_overrun(input int n, input bit ramp);
        int o0;
        int exp_ovr;
        logic [7:0] d;
        exp_ovr  = 0;
        o0       = ovr_cnt;
        rx_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            d = ramp ? 8'(i + 1) : 8'($urandom_range(0, 255));
            if (exp_q.size() < STORE_CAP) exp_q.push_back(d);
            else                          exp_ovr++;
            drive_rx(d, 1'b1);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (ovr_cnt - o0 != exp_ovr) begin
            errors++;
            $display("FAIL overrun_count: got %0d pulses expected %0d", ovr_cnt - o0, exp_ovr);
        end
        checks++;
        if (rx_valid !== 1'b1) begin errors++; $display("FAIL overrun_valid: got %b expected 1", rx_valid); end
        checks++;
        if (rx_data !== exp_q[0]) begin errors++; $display("FAIL overrun_head: got %02h expected %02h", rx_data, exp_q[0]); end
        rx_ready = 1'b1;
        check_rx_stream("overrun_drain");
    endtask

    task automatic test_reset_midframe();
        int f0;
        int o0;
        logic [7:0] dt;
        logic [7:0] dr;
        rx_ready = 1'b1;
        @(negedge clk);
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        ttyo     = 1'b0;
        repeat (88) @(posedge clk);
        #3;
        checks++;
        if (ttyi !== 1'b0) begin errors++; $display("FAIL pre_reset_ttyi: got %b expected 0", ttyi); end
        reset = 1'b0;
        ttyo  = 1'b1;
        #1;
        checks++;
        if (ttyi !== 1'b1) begin errors++; $display("FAIL async_reset_ttyi: got %b expected 1", ttyi); end
        checks++;
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL async_reset_ready: got %b expected 1", tx_ready); end
        checks++;
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL async_reset_rx_valid: got %b expected 0", rx_valid); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(posedge clk);
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        dt = 8'($urandom_range(0, 255));
        dr = 8'($urandom_range(0, 255));
        exp_q.push_back(dr);
        fork
            tx_frames(dt, 8'h00, 1);
            drive_rx(dr, 1'b1);
        join
        check_rx_stream("post_reset_rx");
        checks++;
        if (ferr_cnt - f0 != 0 || ovr_cnt - o0 != 0) begin
            errors++;
            $display("FAIL post_reset_pulses: got ferr=%0d ovr=%0d expected 0 0", ferr_cnt - f0, ovr_cnt - o0);
        end
    endtask

    initial begin
        reset    = 1'b1;
        ttyo     = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        rx_ready = 1'b1;
        test_reset();
        test_rx_basic();
        test_tx();
        test_back_to_back();
        test_break();
        test_overrun(6, 1'b1);
        test_overrun($urandom_range(2, 7), 1'b0);
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "simulation time limit reached");
    end

endmodule
